// File: rtl/rec_fn_pkg.sv
// rtl/rec_fn_pkg.sv - shared constants and stage-1 record for recFN to binary32 conversion
package rec_fn_pkg;

  // Top three bits of the 9-bit recoded exponent select the special classes
  localparam logic [2:0] REC_EXP_ZERO = 3'b000;
  localparam logic [2:0] REC_EXP_INF  = 3'b110;
  localparam logic [2:0] REC_EXP_NAN  = 3'b111;

  // Recoded exponents below this value are subnormal; normals subtract the bias adjust
  localparam int MIN_NORM_EXP = 130;
  localparam int EXP_BIAS_ADJ = 129;

  // FCLASS.S one-hot bit positions
  localparam logic [3:0] CLS_NEG_INF  = 4'd0;
  localparam logic [3:0] CLS_NEG_NORM = 4'd1;
  localparam logic [3:0] CLS_NEG_SUB  = 4'd2;
  localparam logic [3:0] CLS_NEG_ZERO = 4'd3;
  localparam logic [3:0] CLS_POS_ZERO = 4'd4;
  localparam logic [3:0] CLS_POS_SUB  = 4'd5;
  localparam logic [3:0] CLS_POS_NORM = 4'd6;
  localparam logic [3:0] CLS_POS_INF  = 4'd7;
  localparam logic [3:0] CLS_SNAN     = 4'd8;
  localparam logic [3:0] CLS_QNAN     = 4'd9;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [22:0] fract;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        is_sub;
    logic [9:0]  cls;
  } rec_s1_t;

endpackage

// File: rtl/rec_fn_unpack.sv
// rtl/rec_fn_unpack.sv - combinational unpack and classify of a recFN operand
module rec_fn_unpack
  import rec_fn_pkg::*;
(
  input  logic [32:0] in_bits,
  output rec_s1_t     rec
);

  logic [8:0] exp;
  logic       is_zero;
  logic       is_special;
  logic       is_nan;
  logic       is_inf;
  logic       is_sub;

  assign exp        = in_bits[31:23];
  assign is_zero    = (exp[8:6] == REC_EXP_ZERO);
  assign is_special = (exp[8:7] == REC_EXP_INF[2:1]);
  assign is_nan     = (exp[8:6] == REC_EXP_NAN);
  assign is_inf     = (exp[8:6] == REC_EXP_INF);
  assign is_sub     = !is_zero && !is_special && (exp < 9'(MIN_NORM_EXP));

  // Build the stage-1 record, including the one-hot FCLASS mask
  always_comb begin
    rec         = '0;
    rec.sign    = in_bits[32];
    rec.exp     = exp;
    rec.fract   = in_bits[22:0];
    rec.is_zero = is_zero;
    rec.is_inf  = is_inf;
    rec.is_nan  = is_nan;
    rec.is_sub  = is_sub;
    if (is_nan)       rec.cls[in_bits[22] ? CLS_QNAN : CLS_SNAN] = 1'b1;
    else if (is_inf)  rec.cls[in_bits[32] ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
    else if (is_zero) rec.cls[in_bits[32] ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
    else if (is_sub)  rec.cls[in_bits[32] ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
    else              rec.cls[in_bits[32] ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
  end

endmodule

// File: rtl/rec_fn_to_fn_pipe.sv
// rtl/rec_fn_to_fn_pipe.sv - two-stage valid/ready recFN to IEEE binary32 converter
module rec_fn_to_fn_pipe
  import rec_fn_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   io_flush,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [EXP_W+SIG_W:0]   io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [EXP_W+SIG_W-1:0] io_out_bits,
  output logic [9:0]             io_out_class
);

  rec_s1_t     s1_unpacked;
  rec_s1_t     s1_q, s1_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_bits_q, s2_bits_d;
  logic [9:0]  s2_cls_q, s2_cls_d;

  logic        s1_en;
  logic        s2_en;

  logic [4:0]  sub_shift;
  logic [22:0] sub_fract;
  logic [7:0]  exp_out;
  logic [22:0] fract_out;
  logic [31:0] pack_bits;
  logic        unused_exp_msb;

  rec_fn_unpack u_unpack (
    .in_bits (io_in_bits),
    .rec     (s1_unpacked)
  );

  // Each stage advances when it is empty or the stage after it is draining
  assign s2_en          = !s2_valid_q || io_out_ready;
  assign s1_en          = !s1_valid_q || s2_en;
  assign io_in_ready    = s1_en;
  assign io_out_valid   = s2_valid_q;
  assign io_out_bits    = s2_bits_q;
  assign io_out_class   = s2_cls_q;
  assign unused_exp_msb = s1_q.exp[8];

  // Stage 2 packing: denormalise subnormals, rebias normals, force specials
  always_comb begin
    sub_shift = 5'd1 - s1_q.exp[4:0];
    sub_fract = {1'b1, s1_q.fract[22:1]} >> sub_shift;
    exp_out   = s1_q.exp[7:0] - 8'(EXP_BIAS_ADJ);
    fract_out = s1_q.fract;
    if (s1_q.is_nan) begin
      exp_out = 8'hFF;
    end else if (s1_q.is_inf) begin
      exp_out   = 8'hFF;
      fract_out = '0;
    end else if (s1_q.is_zero) begin
      exp_out   = '0;
      fract_out = '0;
    end else if (s1_q.is_sub) begin
      exp_out   = '0;
      fract_out = sub_fract;
    end
    pack_bits = {s1_q.sign, exp_out, fract_out};
  end

  // Next-state for both stages; flush clears valids and beats any same-cycle input
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_bits_d  = s2_bits_q;
    s2_cls_d   = s2_cls_q;
    if (s1_en) begin
      s1_valid_d = io_in_valid;
      if (io_in_valid) s1_d = s1_unpacked;
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_bits_d = pack_bits;
        s2_cls_d  = s1_q.cls;
      end
    end
    if (io_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_bits_q  <= '0;
      s2_cls_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_bits_q  <= s2_bits_d;
      s2_cls_q   <= s2_cls_d;
    end
  end

endmodule
